vmem_req_sequencer: RTL
=======================

VMEM_REQ_SEQUENCER -- requirements
Module: vmem_req_sequencer

Interface
REQ-001 Parameters SHALL be:
- ADDR_W, 4: address width.
- DATA_W, 8: data width.
- DEPTH, 4: command FIFO entries, power of two.
REQ-002 Ports SHALL be as follows; clk and rst are listed first.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  command offered.
- in_ready  out  1  command accepted when high with in_valid.
- in_op  in  1  0 = read, 1 = write.
- in_addr  in  ADDR_W  command address.
- in_data  in  DATA_W  write data, ignored for reads.
- mem_ren  out  1  read strobe to memory.
- mem_wen  out  1  write strobe to memory.
- mem_addr  out  ADDR_W  memory address.
- mem_data  out  DATA_W  memory write data.
- mem_odata  in  DATA_W  memory read data, combinational, valid in the cycle mem_ren is high.
- rsp_valid  out  1  read response available.
- rsp_ready  in  1  response consumed when high with rsp_valid.
- rsp_data  out  DATA_W  read response data.
- occupancy  out  $clog2(DEPTH)+1  FIFO fill level.
- wr_count  out  8  completed writes, wraps at 255 to 0.
- rd_count  out  8  completed reads, wraps at 255 to 0.

Function
REQ-003 The block SHALL push the command when in_valid && in_ready, and in_ready SHALL equal !full.
- No push SHALL occur on a full FIFO, even when a pop happens in the same cycle.
REQ-004 Commands SHALL issue strictly in order from the FIFO head; mem_addr and mem_data SHALL be driven combinationally from the head entry.
REQ-005 A head write SHALL issue whenever the FIFO is non-empty.
- mem_wen=1 for exactly that cycle.
- The head entry is popped and wr_count increments.
REQ-006 A head read SHALL issue only when the response slot is free, i.e. !rsp_valid || rsp_ready.
- mem_ren=1 for that cycle and the head entry is popped.
- mem_odata is captured into rsp_data, with rsp_valid=1 from the next cycle.
- rd_count increments.
REQ-007 A blocked head read SHALL stall every later command, including writes; mem_ren and mem_wen SHALL be 0 while stalled or empty.
REQ-008 mem_ren and mem_wen SHALL never be high in the same cycle.
REQ-009 Latency SHALL be:
- Command accepted at edge N: strobe in cycle N+1.
- Read strobe in cycle N+1: rsp_valid in cycle N+2.
REQ-010 rsp_valid and rsp_data SHALL hold stable until rsp_ready.
- A slot drained in the same cycle as a new read issue SHALL be reloaded with the new data.
- rsp_valid SHALL stay 1 in that case.
REQ-011 On a simultaneous push and pop, occupancy SHALL be unchanged and pointers SHALL wrap modulo DEPTH.
REQ-012 occupancy SHALL equal pushes minus pops since reset, within the range 0..DEPTH.

Reset
REQ-013 When rst=0, the block SHALL asynchronously clear state as follows:
- FIFO pointers, occupancy, rsp_valid, rsp_data, wr_count and rd_count go to 0.
- in_ready goes to 1; mem_ren and mem_wen go to 0.
REQ-014 Reset asserted mid-operation SHALL discard all queued commands and any pending response.
- No strobe SHALL be issued in any cycle where rst=0.
REQ-015 Reset release SHALL take effect synchronously at the next clk rising edge, and the first push SHALL be possible on that edge.

Structure
REQ-016 A shared package vmem_pkg SHALL hold:
- Default ADDR_W and DATA_W.
- The op encoding constants OP_READ=0 and OP_WRITE=1.
- The packed command struct {op, addr, data}.
REQ-017 Command storage SHALL be one sub-module, vmem_sync_fifo, parameterised by width and DEPTH.
- Its outputs SHALL be full, empty, count and the head entry.
- All issue and response logic stays in vmem_req_sequencer.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Write then read: write addr 3 data 8'hA5, then read addr 3, with a memory model attached and rsp_ready=1 -> mem_wen pulse with addr 3, then mem_ren pulse, rsp_data=8'hA5, wr_count=1, rd_count=1.
- Full FIFO: rsp_ready=0 with a pending response, then 5 reads offered back-to-back -> in_ready=0 once occupancy=4, 5th command not accepted, no mem_ren while rsp_valid=1.
- Back-pressure order: head read blocked, write addr 1 queued behind it -> no mem_wen until rsp_ready=1; then read issues before the write.
- Response slot drain and reload: rsp_valid=1 with rsp_ready=1 and the next head a read returning 8'h3C -> rsp_valid stays 1, rsp_data=8'h3C next cycle.
- Reset mid-operation: 3 queued commands, rst=0 for one cycle -> occupancy=0, rsp_valid=0, no strobes afterwards, counters 0.
- Counter wrap: 256 writes -> wr_count returns to 0.

Source files
------------

// File: rtl/vmem_pkg.sv
// Shared widths, op encoding and command payload for the vmem request path.
package vmem_pkg;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 8;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    typedef struct packed {
        logic              op;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cmd_t;

endpackage

// File: rtl/vmem_req_sequencer_if.sv
// Command, memory and response bundle of the vmem request sequencer.
interface vmem_req_sequencer_if #(
    parameter int unsigned ADDR_W = vmem_pkg::ADDR_W,
    parameter int unsigned DATA_W = vmem_pkg::DATA_W,
    parameter int unsigned DEPTH  = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic              in_ready;
    logic              in_op;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_data;

    logic              mem_ren;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] mem_odata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;

    logic [CNT_W-1:0]  occupancy;
    logic [7:0]        wr_count;
    logic [7:0]        rd_count;

    // Requester plus memory side (drives commands, read data and response ready)
    modport master (
        output in_valid, in_op, in_addr, in_data, mem_odata, rsp_ready,
        input  in_ready, mem_ren, mem_wen, mem_addr, mem_data,
        input  rsp_valid, rsp_data, occupancy, wr_count, rd_count
    );

    // Sequencer side
    modport slave (
        input  in_valid, in_op, in_addr, in_data, mem_odata, rsp_ready,
        output in_ready, mem_ren, mem_wen, mem_addr, mem_data,
        output rsp_valid, rsp_data, occupancy, wr_count, rd_count
    );

endinterface

// File: rtl/vmem_sync_fifo.sv
// Single-clock command FIFO with full/empty/count and a show-ahead head entry.
module vmem_sync_fifo #(
    parameter int unsigned WIDTH = 13,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [WIDTH-1:0]           head
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    // A full FIFO refuses pushes even when it pops in the same cycle
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (cnt == CNT_W'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;
    assign head  = mem[rd_ptr];

    // Pointer and fill-level bookkeeping; pointers wrap naturally (DEPTH is a power of two)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !do_pop)      cnt <= cnt + CNT_W'(1);
            else if (do_pop && !do_push) cnt <= cnt - CNT_W'(1);
        end
    end

    // Entry storage, no reset needed since occupancy gates every read
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/vmem_req_sequencer.sv
// In-order memory command sequencer: queues commands, issues strobes, holds one read response.
module vmem_req_sequencer #(
    parameter int unsigned ADDR_W = vmem_pkg::ADDR_W,
    parameter int unsigned DATA_W = vmem_pkg::DATA_W,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    vmem_req_sequencer_if.slave  bus
);
    import vmem_pkg::*;

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned ENT_W = $bits(cmd_t);

    cmd_t              wr_ent;
    cmd_t              head;
    logic [ENT_W-1:0]  head_bits;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  count;
    logic              push;
    logic              issue_wr;
    logic              issue_rd;
    logic [ADDR_W-1:0] head_addr;

    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic [7:0]        wr_cnt_q;
    logic [7:0]        rd_cnt_q;

    // Pack the offered command into a FIFO entry
    always_comb begin
        wr_ent.op   = bus.in_op;
        wr_ent.addr = bus.in_addr;
        wr_ent.data = bus.in_data;
    end

    assign push = bus.in_valid && !full;

    vmem_sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (issue_wr || issue_rd),
        .wdata (wr_ent),
        .full  (full),
        .empty (empty),
        .count (count),
        .head  (head_bits)
    );

    assign head      = cmd_t'(head_bits);
    assign head_addr = head.addr;

    // Head issue decision: writes always go, reads wait for a free response slot and block everything behind them
    always_comb begin
        issue_wr = 1'b0;
        issue_rd = 1'b0;
        if (rst && !empty) begin
            if (head.op == OP_WRITE) begin
                issue_wr = 1'b1;
            end else if (!rsp_valid_q || bus.rsp_ready) begin
                issue_rd = 1'b1;
            end
        end
    end

    // Response slot: load on read issue (also when draining the same cycle), clear when consumed
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else if (issue_rd) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= bus.mem_odata;
        end else if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    // Completion counters, wrapping at 255
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            if (issue_wr) wr_cnt_q <= wr_cnt_q + 8'd1;
            if (issue_rd) rd_cnt_q <= rd_cnt_q + 8'd1;
        end
    end

    assign bus.in_ready  = !full;
    assign bus.mem_wen   = issue_wr;
    assign bus.mem_ren   = issue_rd;
    assign bus.mem_addr  = head_addr;
    assign bus.mem_data  = head.data;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.occupancy = count;
    assign bus.wr_count  = wr_cnt_q;
    assign bus.rd_count  = rd_cnt_q;

endmodule
